// File: rtl/uart_pkg.sv
// Types and constants shared by the UART block and its AXI4-lite feeder.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, AR, R, WAIT, AW_W, B} feeder_state_t;

    localparam logic [1:0]  AXI_RESP_OKAY       = 2'b00;
    localparam logic [2:0]  AXI_PROT_DEFAULT    = 3'b000;
    localparam logic [31:0] UART_STATUS_OFFSET  = 32'h0000_0008;
    localparam logic [31:0] UART_TX_DATA_OFFSET = 32'h0000_0004;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/axi4l_wr_chan.sv
// AW/W channel tracker: both valids rise together, each drops on its own
// handshake, and done_o pulses in the cycle the last one completes.
module axi4l_wr_chan (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic abort_i,
    input  logic awready_i,
    input  logic wready_i,
    output logic awvalid_o,
    output logic wvalid_o,
    output logic done_o
);

    logic aw_pend_q, aw_pend_d;
    logic w_pend_q,  w_pend_d;

    always_comb begin
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        if (abort_i) begin
            aw_pend_d = 1'b0;
            w_pend_d  = 1'b0;
        end else if (start_i) begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
        end else begin
            if (awready_i) aw_pend_d = 1'b0;
            if (wready_i)  w_pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
        end else begin
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
        end
    end

    assign awvalid_o = aw_pend_q;
    assign wvalid_o  = w_pend_q;
    // Something was outstanding and every outstanding channel handshakes now.
    assign done_o = (aw_pend_q | w_pend_q) & (~aw_pend_q | awready_i) & (~w_pend_q | wready_i);

endmodule

// File: rtl/axi4l_uart_feeder.sv
// Byte-stream to AXI4-lite UART feeder: polls TX-full status, then writes the byte.
// Optional AXI wait timeout enabled by defining UART_FEEDER_TIMEOUT_EN.
module axi4l_uart_feeder
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [31:0] STATUS_OFFSET  = UART_STATUS_OFFSET,
    parameter logic [31:0] TX_DATA_OFFSET = UART_TX_DATA_OFFSET,
    parameter int          TX_FULL_BIT    = 1,
    parameter int          POLL_DELAY     = 16,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] axi4l_awaddr,
    output logic        axi4l_awvalid,
    input  logic        axi4l_awready,
    output logic [2:0]  axi4l_awprot,
    output logic [31:0] axi4l_wdata,
    output logic [3:0]  axi4l_wstrb,
    output logic        axi4l_wvalid,
    input  logic        axi4l_wready,
    input  logic [1:0]  axi4l_bresp,
    input  logic        axi4l_bvalid,
    output logic        axi4l_bready,
    output logic [31:0] axi4l_araddr,
    output logic        axi4l_arvalid,
    input  logic        axi4l_arready,
    output logic [2:0]  axi4l_arprot,
    input  logic [31:0] axi4l_rdata,
    input  logic [1:0]  axi4l_rresp,
    input  logic        axi4l_rvalid,
    output logic        axi4l_rready,
    output logic        busy,
    output logic [15:0] err_count
);

    feeder_state_t state_q, state_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
    logic          bready_q, bready_d;
    logic [31:0]   araddr_q, araddr_d;
    logic [31:0]   awaddr_q, awaddr_d;
    logic [7:0]    byte_q, byte_d;
    logic [15:0]   dly_q, dly_d;
    logic [15:0]   err_q, err_d;
    logic          wr_start, wr_abort, wr_done;
    logic          unused_ok;

    assign unused_ok = ^axi4l_rdata;

`ifdef UART_FEEDER_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] tmo_q, tmo_d;
    logic        waiting;
`else
    logic unused_tmo;
    assign unused_tmo = ^32'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_d   = state_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        bready_d  = bready_q;
        araddr_d  = araddr_q;
        awaddr_d  = awaddr_q;
        byte_d    = byte_q;
        dly_d     = dly_q;
        err_d     = err_q;
        wr_start  = 1'b0;
        wr_abort  = 1'b0;
        case (state_q)
            IDLE: if (s_valid) begin
                byte_d    = s_data;
                araddr_d  = BASE_ADDR + STATUS_OFFSET;
                arvalid_d = 1'b1;
                state_d   = AR;
            end
            AR: if (axi4l_arready) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
                state_d   = R;
            end
            R: if (axi4l_rvalid) begin
                rready_d = 1'b0;
                if (axi4l_rresp != AXI_RESP_OKAY) begin
                    err_d   = sat_inc16(err_q);
                    state_d = IDLE;
                end else if (axi4l_rdata[TX_FULL_BIT]) begin
                    dly_d   = 16'(POLL_DELAY);
                    state_d = WAIT;
                end else begin
                    awaddr_d = BASE_ADDR + TX_DATA_OFFSET;
                    wr_start = 1'b1;
                    state_d  = AW_W;
                end
            end
            // Counter reaching zero costs one cycle, so POLL_DELAY=0 still spends a cycle here.
            WAIT: if (dly_q == 16'd0) begin
                arvalid_d = 1'b1;
                state_d   = AR;
            end else begin
                dly_d = dly_q - 16'd1;
            end
            AW_W: if (wr_done) begin
                bready_d = 1'b1;
                state_d  = B;
            end
            B: if (axi4l_bvalid) begin
                bready_d = 1'b0;
                if (axi4l_bresp != AXI_RESP_OKAY) err_d = sat_inc16(err_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef UART_FEEDER_TIMEOUT_EN
        waiting = ((state_q == AR)   && !axi4l_arready) ||
                  ((state_q == R)    && !axi4l_rvalid)  ||
                  ((state_q == AW_W) && !wr_done)       ||
                  ((state_q == B)    && !axi4l_bvalid);
        tmo_d = (state_d != state_q || !waiting) ? 32'd0 : tmo_q + 32'd1;
        // Bail out of a hung slave: drops valids mid-transaction, deliberately non-AXI.
        if (waiting && tmo_q == TMO_LAST) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            bready_d  = 1'b0;
            wr_abort  = 1'b1;
            err_d     = sat_inc16(err_q);
            state_d   = IDLE;
            tmo_d     = 32'd0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            bready_q  <= 1'b0;
            araddr_q  <= 32'd0;
            awaddr_q  <= 32'd0;
            byte_q    <= 8'd0;
            dly_q     <= 16'd0;
            err_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            bready_q  <= bready_d;
            araddr_q  <= araddr_d;
            awaddr_q  <= awaddr_d;
            byte_q    <= byte_d;
            dly_q     <= dly_d;
            err_q     <= err_d;
        end
    end

`ifdef UART_FEEDER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) tmo_q <= 32'd0;
        else     tmo_q <= tmo_d;
    end
`endif

    axi4l_wr_chan u_wr_chan (
        .clk       (clk),
        .rst       (rst),
        .start_i   (wr_start),
        .abort_i   (wr_abort),
        .awready_i (axi4l_awready),
        .wready_i  (axi4l_wready),
        .awvalid_o (axi4l_awvalid),
        .wvalid_o  (axi4l_wvalid),
        .done_o    (wr_done)
    );

    assign s_ready       = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign axi4l_araddr  = araddr_q;
    assign axi4l_arvalid = arvalid_q;
    assign axi4l_arprot  = AXI_PROT_DEFAULT;
    assign axi4l_rready  = rready_q;
    assign axi4l_awaddr  = awaddr_q;
    assign axi4l_awprot  = AXI_PROT_DEFAULT;
    assign axi4l_wdata   = {24'h0, byte_q};
    assign axi4l_wstrb   = 4'b0001;
    assign axi4l_bready  = bready_q;
    assign err_count     = err_q;

endmodule
